// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared types and helpers for the byte-addressable data
//                memory / load-store unit. Holds the RV32 funct3 encodings,
//                the byte-enable type, the response-register state encoding
//                and the access-legality helper functions.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // RV32 load/store size encodings. Bit 2 selects unsigned on loads.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef logic [3:0] byte_en_t;

    // One-entry response register occupancy.
    typedef enum logic [0:0] {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_t;

    // Halfwords need an even address, words need a 4-byte aligned address.
    // Only the low two funct3 bits carry the size, so the unsigned variants
    // share the check with their signed counterparts.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] offset);
        logic r;
        r = 1'b0;
        case (funct3[1:0])
            2'b01:   r = offset[0];
            2'b10:   r = (offset != 2'b00);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Loads accept B/H/W/BU/HU; stores accept only B/H/W.
    function automatic logic is_illegal(input logic       we,
                                        input logic [2:0] funct3);
        logic r;
        r = 1'b1;
        if (we) begin
            r = !((funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W));
        end else begin
            r = !((funct3 == F3_B)  || (funct3 == F3_H) || (funct3 == F3_W) ||
                  (funct3 == F3_BU) || (funct3 == F3_HU));
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_lane_align
//  Description : Combinational lane steering for a 32-bit, 4-lane data
//                memory. Produces byte enables and lane-replicated store data
//                for stores, and picks/extends the addressed byte or halfword
//                of the raw memory word for loads.
//  Ports       : i_funct3   - RISC-V funct3 (size / sign)
//                i_offset   - byte offset within the word (addr[1:0])
//                i_raw      - word currently stored at the addressed index
//                i_wdata    - right-aligned store data (rs2)
//                o_byte_en  - per-lane write enable (0 for illegal funct3)
//                o_wdata    - store data replicated onto every lane
//                o_rdata    - extended load result (0 for illegal funct3)
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_raw,
    input  logic [31:0] i_wdata,
    output byte_en_t    o_byte_en,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_raw[{i_offset, 3'b000} +: 8];
    assign w_half = i_offset[1] ? i_raw[31:16] : i_raw[15:0];

    // Store side: replicating the data onto every lane lets the byte enables
    // alone decide which lanes are written, with no data shifter.
    always_comb begin
        o_byte_en = 4'b0000;
        o_wdata   = 32'h0;
        case (i_funct3)
            F3_B: begin
                o_byte_en = byte_en_t'(4'b0001 << i_offset);
                o_wdata   = {4{i_wdata[7:0]}};
            end
            F3_H: begin
                o_byte_en = i_offset[1] ? 4'b1100 : 4'b0011;
                o_wdata   = {2{i_wdata[15:0]}};
            end
            F3_W: begin
                o_byte_en = 4'b1111;
                o_wdata   = i_wdata;
            end
            default: begin
                o_byte_en = 4'b0000;
                o_wdata   = 32'h0;
            end
        endcase
    end

    // Load side.
    always_comb begin
        o_rdata = 32'h0;
        case (i_funct3)
            F3_B:    o_rdata = {{24{w_byte[7]}},  w_byte};
            F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
            F3_W:    o_rdata = i_raw;
            F3_BU:   o_rdata = {24'h0, w_byte};
            F3_HU:   o_rdata = {16'h0, w_half};
            default: o_rdata = 32'h0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/datamemory_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : datamemory_lsu
//  Description : Byte-addressable RV32 data memory with LB/LH/LW/LBU/LHU and
//                SB/SH/SW support. Valid/ready request channel, one-entry
//                registered response channel with backpressure, 1-cycle
//                latency. Misaligned or illegal accesses respond with
//                rsp_err=1, rsp_rdata=0 and never write memory.
//  Ports       : clk, reset (async, active-high)
//                req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata
//                rsp_valid/rsp_ready/rsp_rdata/rsp_err
//  Revision    : 1.0 - initial release
// ============================================================================
module datamemory_lsu
    import dmem_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    localparam int c_DEPTH = 2 ** (DM_ADDRESS - 2);

    // Storage is deliberately not reset: it models a RAM macro.
    logic [DATA_W-1:0]     r_mem [c_DEPTH];

    logic [DM_ADDRESS-3:0] w_word_idx;
    logic [1:0]            w_offset;
    logic                  w_accept;
    logic                  w_err;
    logic                  w_wr_en;
    logic [DATA_W-1:0]     w_raw;
    byte_en_t              w_byte_en;
    logic [DATA_W-1:0]     w_wdata_rep;
    logic [DATA_W-1:0]     w_load;

    rsp_state_t            r_state;
    rsp_state_t            w_state_nxt;
    logic [DATA_W-1:0]     r_rdata;
    logic                  r_err;

    assign w_word_idx = req_addr[DM_ADDRESS-1:2];
    assign w_offset   = req_addr[1:0];

    // The output register can take a new entry whenever it is empty or its
    // current entry is leaving on this same edge.
    assign req_ready  = (r_state == RSP_EMPTY) || rsp_ready;
    assign w_accept   = req_valid && req_ready;

    assign w_err      = is_misaligned(req_funct3, w_offset) ||
                        is_illegal(req_we, req_funct3);
    assign w_wr_en    = w_accept && req_we && !w_err;

    assign w_raw      = r_mem[w_word_idx];

    dmem_lane_align u_lane_align (
        .i_funct3  (req_funct3),
        .i_offset  (w_offset),
        .i_raw     (w_raw),
        .i_wdata   (req_wdata),
        .o_byte_en (w_byte_en),
        .o_wdata   (w_wdata_rep),
        .o_rdata   (w_load)
    );

    // Byte-lane write port; commits on the accepting edge.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (w_byte_en[i]) begin
                    r_mem[w_word_idx][i*8 +: 8] <= w_wdata_rep[i*8 +: 8];
                end
            end
        end
    end

    // Response register occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RSP_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RSP_EMPTY: begin
                if (w_accept) w_state_nxt = RSP_FULL;
            end
            RSP_FULL: begin
                if (w_accept)       w_state_nxt = RSP_FULL;
                else if (rsp_ready) w_state_nxt = RSP_EMPTY;
            end
            default: w_state_nxt = RSP_EMPTY;
        endcase
    end

    // Payload only changes on accept, so it stays stable while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_rdata <= (req_we || w_err) ? '0 : w_load;
            r_err   <= w_err;
        end
    end

    assign rsp_valid = (r_state == RSP_FULL);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule
`default_nettype wire

// File: doc/datamemory_lsu.md
Name: datamemory_lsu

Overview:
Byte-addressable RISC-V data memory with load/store size handling (LB/LH/LW/LBU/LHU, SB/SH/SW) and per-byte write enables. Sits behind the ALU/EX stage and replaces the word-only combinational data memory. A valid/ready request channel and a registered response channel with backpressure let the pipeline stall on the data port. Misaligned or illegal accesses are flagged and never modify memory.

Parameters:
DM_ADDRESS, 9, byte-address width; storage is 2**(DM_ADDRESS-2) words.
DATA_W, 32, word width; fixed at 32 for RV32 (funct3 decode assumes 4 byte lanes).

Ports:
clk  in  1  single clock, all state on rising edge
reset  in  1  asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  block can accept request this cycle
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V funct3 (size/sign)
req_addr  in  DM_ADDRESS  byte address (ALU result LSBs)
req_wdata  in  DATA_W  store data (rs2), right-aligned
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  DATA_W  load result, extended; 0 for stores and errors
rsp_err  out  1  misaligned or illegal funct3

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- Reset: rsp_valid=0, rsp_rdata=0, rsp_err=0. Memory array is not cleared. A pending response is discarded. req_ready=1 once reset deasserts.
- Handshake: request accepted on a rising edge with req_valid && req_ready. req_ready = !rsp_valid || rsp_ready (one-entry output register, full throughput).
- Latency: exactly 1 cycle. Response registered on the accepting edge. rsp_valid, rsp_rdata and rsp_err are held stable while rsp_valid && !rsp_ready.
- Every accepted request, load or store, produces exactly one response. Store response: rsp_rdata=0.
- Response register states: EMPTY and FULL.
  - EMPTY -> FULL on accept.
  - FULL -> FULL on accept with rsp_ready (back-to-back).
  - FULL -> EMPTY on rsp_ready without accept.
- Address decode: word index = req_addr[DM_ADDRESS-1:2]; byte offset = req_addr[1:0].
- Load funct3:
  - 000 LB: sign-extend byte at offset.
  - 001 LH: sign-extend halfword at offset[1].
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend halfword.
  - 011/110/111: illegal.
- Store funct3:
  - 000 SB: byte enable 1<<offset, data = wdata[7:0] replicated to all lanes.
  - 001 SH: enable 0011 or 1100, data = wdata[15:0] replicated.
  - 010 SW: enable 1111.
  - Other values: illegal.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0. Response has rsp_err=1, rsp_rdata=0; no write occurs.
- Illegal funct3: same response as misaligned (rsp_err=1, rsp_rdata=0); no write.
- Store write commits on the accepting edge.
- A load accepted on a later cycle sees the new data. No same-cycle read/write conflict exists (one request per cycle).
- Reads of never-written locations return X in simulation. The bench must not check them.

Decomposition:
- Package dmem_pkg:
  - funct3 constants F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
  - Typedef byte_en_t (logic [3:0]).
  - Function is_misaligned(funct3, addr[1:0]).
- Sub-module dmem_lane_align (combinational):
  - Inputs: funct3, offset, raw word, store data.
  - Outputs: byte_en, lane-replicated wdata, extended load data.
- Top holds the storage array, the write port and the response register.

Test Plan:
- SW addr 0x010 data 0xDEADBEEF, then LW 0x010 -> rsp_rdata=0xDEADBEEF, rsp_err=0, each response 1 cycle after accept.
- SB addr 0x013 data 0x00000080, then LB 0x013 -> 0xFFFFFF80; LBU 0x013 -> 0x00000080; LW 0x010 -> 0x80ADBEEF.
- SH addr 0x022 data 0x1234ABCD after SW 0x020 0 -> LW 0x020 = 0xABCD0000; LH 0x022 -> 0xFFFFABCD; LHU 0x022 -> 0x0000ABCD.
- LW addr 0x011 and SH addr 0x021 -> rsp_err=1, rsp_rdata=0; subsequent LW 0x020 still 0xABCD0000 (no write).
- Backpressure: hold rsp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0, response held stable; release -> back-to-back responses one per cycle, none lost or duplicated.
- Assert reset while rsp_valid=1 -> rsp_valid=0, rsp_rdata=0, rsp_err=0 immediately (async); after release, LW of previously written address returns stored data.
